// File: rtl/jornal_input_conditioner.sv
// Conditions the six raw panel/coin lines (sync, debounce, rising edge) and feeds
// the vending FSM one registered pulse at a time through a priority arbiter.
module jornal_input_conditioner #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_inicio,
  input  logic raw_c,
  input  logic raw_u,
  input  logic raw_jl,
  input  logic raw_jn,
  input  logic raw_dt,
  output logic inicio,
  output logic c,
  output logic u,
  output logic jl,
  output logic jn,
  output logic dt,
  output logic busy
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  // Line index: 0 inicio, 1 c, 2 u, 3 jl, 4 jn, 5 dt
  logic [5:0] raw_vec;
  logic [5:0] s1_reg, s2_reg;
  logic [5:0] db_vec;
  logic [5:0] rise;
  logic [5:0] pend_reg;
  logic [5:0] sel_reg, sel_next;
  logic [5:0] out_reg;
  logic [5:0] clr;
  state_t     state_reg;
  logic [GW-1:0] gap_reg;

  assign raw_vec = {raw_dt, raw_jn, raw_jl, raw_u, raw_c, raw_inicio};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= raw_vec;
      s2_reg <= s1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_deb
      logic [CNT_W-1:0] cnt_reg;
      logic             db_reg;
      logic             at_limit;

      assign at_limit   = (cnt_reg == CNT_W'(DEB_CYCLES - 1));
      assign db_vec[gi] = db_reg;
      // The flip to 1 and the pending set land on the same edge
      assign rise[gi]   = s2_reg[gi] & ~db_reg & at_limit;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg <= '0;
          db_reg  <= 1'b0;
        end else if (s2_reg[gi] == db_reg) begin
          cnt_reg <= '0;
        end else if (at_limit) begin
          db_reg  <= s2_reg[gi];
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  // Priority dt > c > u > jl > jn > inicio, one-hot result
  always_comb begin
    sel_next = '0;
    if (pend_reg[5])      sel_next = 6'b100000;
    else if (pend_reg[1]) sel_next = 6'b000010;
    else if (pend_reg[2]) sel_next = 6'b000100;
    else if (pend_reg[3]) sel_next = 6'b001000;
    else if (pend_reg[4]) sel_next = 6'b010000;
    else if (pend_reg[0]) sel_next = 6'b000001;
  end

  assign clr = (state_reg == PULSE) ? sel_reg : 6'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      out_reg   <= '0;
      gap_reg   <= '0;
      pend_reg  <= '0;
    end else begin
      // A new rise on the served line wins over the clear
      pend_reg <= (pend_reg & ~clr) | rise;
      case (state_reg)
        IDLE: begin
          out_reg <= '0;
          if (|pend_reg) begin
            state_reg <= PULSE;
            sel_reg   <= sel_next;
            out_reg   <= sel_next;
          end
        end
        PULSE: begin
          out_reg <= '0;
          if (GAP_CYCLES > 0) begin
            state_reg <= GAP;
            gap_reg   <= '0;
          end else begin
            state_reg <= IDLE;
          end
        end
        GAP: begin
          out_reg <= '0;
          if (gap_reg == GW'(GAP_CYCLES - 1)) state_reg <= IDLE;
          else                                gap_reg   <= gap_reg + 1'b1;
        end
        default: begin
          out_reg   <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign inicio = out_reg[0];
  assign c      = out_reg[1];
  assign u      = out_reg[2];
  assign jl     = out_reg[3];
  assign jn     = out_reg[4];
  assign dt     = out_reg[5];
  assign busy   = (|pend_reg) | (state_reg != IDLE);

endmodule
